// File: rtl/friet_stream_packer.sv
// Packs a stream of narrow words into wide blocks and queues them behind a
// small FIFO, with optional 0x01 end-of-message padding.
module friet_stream_packer #(
  parameter int DIN_WIDTH       = 32,
  parameter int DIN_SIZE_WIDTH  = 2,
  parameter int DOUT_WIDTH      = 128,
  parameter int DOUT_SIZE_WIDTH = 4,
  parameter int DEPTH_WIDTH     = 1,
  parameter int PAD_ENABLE      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIN_WIDTH-1:0]       din,
  input  logic [DIN_SIZE_WIDTH:0]    din_size,
  input  logic                       din_last,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [DOUT_WIDTH-1:0]      dout,
  output logic [DOUT_SIZE_WIDTH:0]   dout_size,
  output logic                       dout_last,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [DEPTH_WIDTH:0]       occupancy
);

  localparam int NB     = DIN_WIDTH / 8;
  localparam int W      = DOUT_WIDTH / DIN_WIDTH;
  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int WCNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int CW     = DOUT_SIZE_WIDTH + 1;
  localparam int OW     = DEPTH_WIDTH + 1;
  localparam int SW     = DIN_SIZE_WIDTH + 1;

  localparam logic [0:0] ACCUM       = 1'b0;
  localparam logic [0:0] PAD_PENDING = 1'b1;

  logic [0:0]            state;
  logic [WCNT_W-1:0]     wcnt;
  logic [DOUT_WIDTH-1:0] asm_data;
  logic [CW-1:0]         asm_count;

  logic [DOUT_WIDTH-1:0] q_data [DEPTH];
  logic [CW-1:0]         q_size [DEPTH];
  logic                  q_last [DEPTH];
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [OW-1:0]          occ;

  logic                  pad_on;
  logic                  pop;
  logic                  space;
  logic                  accept;
  logic                  full_word;
  logic                  slot_last;
  logic                  complete;
  logic                  to_pad;
  logic                  push_word;
  logic                  push_pad;
  logic                  push;
  logic [DIN_WIDTH-1:0]  word_mod;
  logic [DOUT_WIDTH-1:0] blk_data;
  logic [CW-1:0]         blk_count;
  logic [DOUT_WIDTH-1:0] push_data;
  logic [CW-1:0]         push_size;
  logic                  push_last;

  assign pad_on    = (PAD_ENABLE != 0);
  assign pop       = (occ != '0) && dout_ready;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign space     = (occ < OW'(DEPTH)) || pop;
  assign din_ready = !rst && (state == ACCUM) && space;
  assign accept    = din_valid && din_ready;
  assign full_word = (din_size == SW'(NB));
  assign slot_last = (wcnt == WCNT_W'(W - 1));
  assign complete  = din_last || slot_last;
  assign to_pad    = pad_on && din_last && full_word && slot_last;
  assign push_word = accept && complete;
  assign push_pad  = (state == PAD_PENDING) && space;
  assign push      = push_word || push_pad;

  // Pad byte goes right after the last valid byte; bytes above it are cleared.
  always_comb begin
    word_mod = din;
    if (pad_on && din_last && !full_word) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (i == 32'(din_size))
          word_mod[i*8 +: 8] = 8'h01;
        else if (i > 32'(din_size))
          word_mod[i*8 +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    blk_data = asm_data | (DOUT_WIDTH'(word_mod) << (32'(wcnt) * DIN_WIDTH));
    if (pad_on && din_last && full_word && !slot_last)
      blk_data = blk_data | (DOUT_WIDTH'(8'h01) << ((32'(wcnt) + 1) * DIN_WIDTH));
    blk_count = asm_count + CW'(din_size);
  end

  always_comb begin
    push_data = blk_data;
    push_size = blk_count;
    push_last = din_last && !to_pad;
    if (push_pad) begin
      push_data = DOUT_WIDTH'(8'h01);
      push_size = '0;
      push_last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      wcnt      <= '0;
      asm_data  <= '0;
      asm_count <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) begin
        q_data[d] <= '0;
        q_size[d] <= '0;
        q_last[d] <= 1'b0;
      end
    end else begin
      if (accept) begin
        if (complete) begin
          wcnt      <= '0;
          asm_data  <= '0;
          asm_count <= '0;
          if (to_pad)
            state <= PAD_PENDING;
        end else begin
          wcnt      <= wcnt + WCNT_W'(1);
          asm_data  <= blk_data;
          asm_count <= blk_count;
        end
      end
      if (push_pad)
        state <= ACCUM;
      if (push) begin
        q_data[wr_ptr] <= push_data;
        q_size[wr_ptr] <= push_size;
        q_last[wr_ptr] <= push_last;
        wr_ptr         <= wr_ptr + DEPTH_WIDTH'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  assign dout       = q_data[rd_ptr];
  assign dout_size  = q_size[rd_ptr];
  assign dout_last  = q_last[rd_ptr];
  assign dout_valid = (occ != '0);
  assign occupancy  = occ;

endmodule

// File: tb/tb_friet_stream_packer.sv
// Directed bench for friet_stream_packer: one instance without padding, one with.
module tb_friet_stream_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  din;
  logic [2:0]   din_size;
  logic         din_last;
  logic         valid0, valid1;
  logic         dout_ready;
  logic         rdy0, rdy1;
  logic [127:0] dout0, dout1;
  logic [4:0]   dsz0, dsz1;
  logic         dl0, dl1, dv0, dv1;
  logic [1:0]   occ0, occ1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  friet_stream_packer #(
    .DIN_WIDTH(32), .DIN_SIZE_WIDTH(2), .DOUT_WIDTH(128), .DOUT_SIZE_WIDTH(4),
    .DEPTH_WIDTH(1), .PAD_ENABLE(0)
  ) u_nopad (
    .clk(clk), .rst(rst), .din(din), .din_size(din_size), .din_last(din_last),
    .din_valid(valid0), .din_ready(rdy0), .dout(dout0), .dout_size(dsz0),
    .dout_last(dl0), .dout_valid(dv0), .dout_ready(dout_ready), .occupancy(occ0)
  );

  friet_stream_packer #(
    .DIN_WIDTH(32), .DIN_SIZE_WIDTH(2), .DOUT_WIDTH(128), .DOUT_SIZE_WIDTH(4),
    .DEPTH_WIDTH(1), .PAD_ENABLE(1)
  ) u_pad (
    .clk(clk), .rst(rst), .din(din), .din_size(din_size), .din_last(din_last),
    .din_valid(valid1), .din_ready(rdy1), .dout(dout1), .dout_size(dsz1),
    .dout_last(dl1), .dout_valid(dv1), .dout_ready(dout_ready), .occupancy(occ1)
  );

  typedef struct {
    bit           sel;
    bit           vld;
    logic [31:0]  din;
    logic [2:0]   size;
    bit           last;
    bit           rdy;
    bit           dv;
    logic [127:0] dout;
    logic [4:0]   dsize;
    bit           dlast;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit sel, bit vld, logic [31:0] d, int s, bit l,
                              bit rdy, bit dv, logic [127:0] o, int os, bit ol);
    vec_t v;
    v.sel = sel; v.vld = vld; v.din = d; v.size = 3'(s); v.last = l;
    v.rdy = rdy; v.dv = dv; v.dout = o; v.dsize = 5'(os); v.dlast = ol;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send0(input logic [31:0] d, input logic [2:0] s, input logic l);
    int n;
    @(negedge clk);
    din = d; din_size = s; din_last = l; valid0 = 1'b1;
    #1;
    n = 0;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy0) begin
      checks++;
      errors++;
      $display("FAIL send0_timeout: din_ready got 0 expected 1");
    end else begin
      @(posedge clk);
    end
    #1;
    valid0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; din = '0; din_size = '0; din_last = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; dout_ready = 1'b1;

    // Without padding: full message, partial last word, uncompacted sizes, empty last.
    vq.push_back(mk(0,1,32'h03020100,4,0, 1,0,'0,0,0));
    vq.push_back(mk(0,1,32'h07060504,4,0, 1,0,'0,0,0));
    vq.push_back(mk(0,1,32'h0B0A0908,4,0, 1,0,'0,0,0));
    vq.push_back(mk(0,1,32'h0F0E0D0C,4,1, 1,1,128'h0F0E0D0C0B0A090807060504_03020100,16,1));
    vq.push_back(mk(0,0,32'h0,0,0,        1,0,'0,0,0));
    vq.push_back(mk(0,1,32'hEEDDCCBB,3,1, 1,1,128'hEEDDCCBB,3,1));
    vq.push_back(mk(0,0,32'h0,0,0,        1,0,'0,0,0));
    vq.push_back(mk(0,1,32'h1111BBAA,2,0, 1,0,'0,0,0));
    vq.push_back(mk(0,1,32'h2222DDCC,2,1, 1,1,128'h2222DDCC_1111BBAA,4,1));
    vq.push_back(mk(0,0,32'h0,0,0,        1,0,'0,0,0));
    vq.push_back(mk(0,1,32'hAABBCCDD,0,1, 1,1,128'hAABBCCDD,0,1));
    vq.push_back(mk(0,0,32'h0,0,0,        1,0,'0,0,0));
    // With padding: partial last word, full-block pad, mid-block pad, empty last.
    vq.push_back(mk(1,1,32'h33221100,4,0, 1,0,'0,0,0));
    vq.push_back(mk(1,1,32'hFFDDCCBB,3,1, 1,1,128'h01DDCCBB_33221100,7,1));
    vq.push_back(mk(1,0,32'h0,0,0,        1,0,'0,0,0));
    vq.push_back(mk(1,1,32'h03020100,4,0, 1,0,'0,0,0));
    vq.push_back(mk(1,1,32'h07060504,4,0, 1,0,'0,0,0));
    vq.push_back(mk(1,1,32'h0B0A0908,4,0, 1,0,'0,0,0));
    vq.push_back(mk(1,1,32'h0F0E0D0C,4,1, 1,1,128'h0F0E0D0C0B0A090807060504_03020100,16,0));
    vq.push_back(mk(1,0,32'h0,0,0,        0,1,128'h01,0,1));
    vq.push_back(mk(1,0,32'h0,0,0,        1,0,'0,0,0));
    vq.push_back(mk(1,1,32'h44332211,4,0, 1,0,'0,0,0));
    vq.push_back(mk(1,1,32'h88776655,4,1, 1,1,128'h00000001_88776655_44332211,8,1));
    vq.push_back(mk(1,0,32'h0,0,0,        1,0,'0,0,0));
    vq.push_back(mk(1,1,32'hAABBCCDD,0,1, 1,1,128'h01,0,1));
    vq.push_back(mk(1,0,32'h0,0,0,        1,0,'0,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din_ready", rdy0, 1'b0);
    chk("rst_dout_valid", dv0, 1'b0);
    chk("rst_dout", dout0, 128'h0);
    chk("rst_dout_size", dsz0, 5'd0);
    chk("rst_dout_last", dl0, 1'b0);
    chk("rst_occupancy", occ0, 2'd0);
    chk("rst_pad_dout_valid", dv1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", rdy0, 1'b1);
    chk("post_rst_ready1", rdy1, 1'b1);

    foreach (vq[i]) begin
      v = vq[i];
      @(negedge clk);
      din = v.din; din_size = v.size; din_last = v.last;
      valid0 = v.vld && !v.sel;
      valid1 = v.vld && v.sel;
      #1;
      chk($sformatf("row%0d_din_ready", i), v.sel ? rdy1 : rdy0, v.rdy);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_dout_valid", i), v.sel ? dv1 : dv0, v.dv);
      if (v.dv) begin
        chk($sformatf("row%0d_dout", i), v.sel ? dout1 : dout0, v.dout);
        chk($sformatf("row%0d_dout_size", i), v.sel ? dsz1 : dsz0, v.dsize);
        chk($sformatf("row%0d_dout_last", i), v.sel ? dl1 : dl0, v.dlast);
      end
    end
    @(negedge clk);
    valid0 = 1'b0; valid1 = 1'b0;

    // Backpressure: fill both queue slots, then push and pop together at full.
    dout_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send0(32'h01010101 * k, 3'd4, 1'b0);
      if (k == 3) begin
        chk("bp_occ_after4", occ0, 2'd1);
        chk("bp_head_after4", dout0, 128'h03030303_02020202_01010101_00000000);
      end
    end
    chk("bp_occ_after8", occ0, 2'd2);
    @(negedge clk);
    #1;
    chk("bp_ready_full", rdy0, 1'b0);
    chk("bp_head_held", dout0, 128'h03030303_02020202_01010101_00000000);
    din = 32'h08080808; din_size = 3'd4; din_last = 1'b1; valid0 = 1'b1;
    dout_ready = 1'b1;
    #1;
    chk("bp_ready_with_pop", rdy0, 1'b1);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    chk("bp_occ_pushpop", occ0, 2'd2);
    chk("bp_head2", dout0, 128'h07070707_06060606_05050505_04040404);
    chk("bp_head2_size", dsz0, 5'd16);
    chk("bp_head2_last", dl0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_occ_drain1", occ0, 2'd1);
    chk("bp_head3", dout0, 128'h08080808);
    chk("bp_head3_size", dsz0, 5'd4);
    chk("bp_head3_last", dl0, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_drained_valid", dv0, 1'b0);
    chk("bp_drained_occ", occ0, 2'd0);

    // Mid-message reset discards both the queued block and the partial one.
    dout_ready = 1'b0;
    for (int k = 0; k < 6; k++)
      send0(32'h11111111 * (k + 1), 3'd4, 1'b0);
    chk("mr_occ_before", occ0, 2'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_ready_in_rst", rdy0, 1'b0);
    @(posedge clk);
    #1;
    chk("mr_occ", occ0, 2'd0);
    chk("mr_valid", dv0, 1'b0);
    chk("mr_dout", dout0, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    dout_ready = 1'b1;
    send0(32'hCAFEBABE, 3'd4, 1'b1);
    chk("mr_next_valid", dv0, 1'b1);
    chk("mr_next_dout", dout0, 128'hCAFEBABE);
    chk("mr_next_size", dsz0, 5'd4);
    chk("mr_next_last", dl0, 1'b1);
    @(posedge clk);
    #1;
    chk("mr_next_popped", dv0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
